// File: rtl/cubehash_pkg.sv
// Shared definitions for the CubeHash16/32-256 core: round counts, IV
// constants, FSM encoding, state-word container and small helpers.
package cubehash_pkg;

    localparam int unsigned ROUNDS_BLOCK = 16;
    localparam int unsigned ROUNDS_INIT  = 160;
    localparam int unsigned ROUNDS_FINAL = 160;

    localparam logic [31:0] IV_X0 = 32'd32;
    localparam logic [31:0] IV_X1 = 32'd32;
    localparam logic [31:0] IV_X2 = 32'd16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IVGEN  = 3'd1,
        ST_READY  = 3'd2,
        ST_ROUND  = 3'd3,
        ST_FINAL  = 3'd4,
        ST_OUTPUT = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Word i of the 1024-bit state lives in bits [32*i +: 32].
    typedef logic [31:0][31:0] state_words_t;

    // 32-bit rotate left by s (0..31).
    function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] s);
        return (v << s) | (v >> (6'd32 - {1'b0, s}));
    endfunction

    // State loaded by init before the IV-generation rounds.
    function automatic state_words_t iv_state();
        state_words_t v;
        v        = '0;
        v[5'd0]  = IV_X0;
        v[5'd1]  = IV_X1;
        v[5'd2]  = IV_X2;
        return v;
    endfunction

endpackage

// File: rtl/cubehash_round.sv
// One complete CubeHash round, purely combinational. The ten steps are
// applied in order to a working copy of the state; swaps are done pairwise.
module cubehash_round
    import cubehash_pkg::*;
(
    input  logic [1023:0] x,
    output logic [1023:0] y
);

    state_words_t w_s;
    logic [31:0]  tmp_s;

    // Apply add / rotate / swap / xor / swap twice (rotations 7 then 11).
    always_comb begin
        w_s   = state_words_t'(x);
        tmp_s = 32'd0;

        // 1. x[1jklm] += x[0jklm]
        for (int i = 0; i < 16; i++) begin
            w_s[5'(i + 16)] = w_s[5'(i + 16)] + w_s[5'(i)];
        end
        // 2. x[0jklm] rotl 7
        for (int i = 0; i < 16; i++) begin
            w_s[5'(i)] = rotl32(w_s[5'(i)], 5'd7);
        end
        // 3. swap x[00klm] with x[01klm]
        for (int i = 0; i < 8; i++) begin
            tmp_s           = w_s[5'(i)];
            w_s[5'(i)]      = w_s[5'(i + 8)];
            w_s[5'(i + 8)]  = tmp_s;
        end
        // 4. x[0jklm] ^= x[1jklm]
        for (int i = 0; i < 16; i++) begin
            w_s[5'(i)] = w_s[5'(i)] ^ w_s[5'(i + 16)];
        end
        // 5. swap x[1jk0m] with x[1jk1m]
        for (int h = 0; h < 4; h++) begin
            for (int m = 0; m < 2; m++) begin
                tmp_s                       = w_s[5'(16 + 4 * h + m)];
                w_s[5'(16 + 4 * h + m)]     = w_s[5'(16 + 4 * h + m + 2)];
                w_s[5'(16 + 4 * h + m + 2)] = tmp_s;
            end
        end
        // 6. x[1jklm] += x[0jklm]
        for (int i = 0; i < 16; i++) begin
            w_s[5'(i + 16)] = w_s[5'(i + 16)] + w_s[5'(i)];
        end
        // 7. x[0jklm] rotl 11
        for (int i = 0; i < 16; i++) begin
            w_s[5'(i)] = rotl32(w_s[5'(i)], 5'd11);
        end
        // 8. swap x[0j0lm] with x[0j1lm]
        for (int j = 0; j < 2; j++) begin
            for (int lm = 0; lm < 4; lm++) begin
                tmp_s                    = w_s[5'(8 * j + lm)];
                w_s[5'(8 * j + lm)]      = w_s[5'(8 * j + lm + 4)];
                w_s[5'(8 * j + lm + 4)]  = tmp_s;
            end
        end
        // 9. x[0jklm] ^= x[1jklm]
        for (int i = 0; i < 16; i++) begin
            w_s[5'(i)] = w_s[5'(i)] ^ w_s[5'(i + 16)];
        end
        // 10. swap x[1jkl0] with x[1jkl1]
        for (int p = 0; p < 8; p++) begin
            tmp_s                  = w_s[5'(16 + 2 * p)];
            w_s[5'(16 + 2 * p)]    = w_s[5'(16 + 2 * p + 1)];
            w_s[5'(16 + 2 * p + 1)] = tmp_s;
        end

        y = w_s;
    end

endmodule

// File: rtl/cubehash_top.sv
// Iterative CubeHash16/32-256 core: one round per clock, 16-bit load/fetch
// handshake with a registered one-cycle ack.
// Optional build macro CUBEHASH_ERR_EN adds a sticky err output flagging
// requests that the core cannot honour in its current state.
module cubehash_top
    import cubehash_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        load,
    input  logic        fetch,
    input  logic [15:0] idata,
    output logic        ack,
    output logic [15:0] odata
`ifdef CUBEHASH_ERR_EN
    ,
    output logic        err
`endif
);

    localparam logic [7:0] RCNT_INIT_LAST  = 8'(ROUNDS_INIT - 1);
    localparam logic [7:0] RCNT_BLOCK_LAST = 8'(ROUNDS_BLOCK - 1);
    localparam logic [7:0] RCNT_FINAL_LAST = 8'(ROUNDS_FINAL - 1);

    state_t       state_r;
    state_t       state_next_s;
    state_words_t x_r;
    state_words_t x_round_s;
    logic [3:0]   n_r;
    logic [3:0]   k_r;
    logic [7:0]   rcnt_r;
    logic [7:0]   rcnt_last_s;
    logic         round_en_s;
    logic         round_last_s;
    logic         take_load_s;
    logic         start_final_s;
    logic         deliver_s;
    logic [4:0]   load_idx_s;
    logic [4:0]   out_idx_s;
    logic [31:0]  load_word_s;

    cubehash_round u_round (
        .x (x_r),
        .y (x_round_s)
    );

    // Halfword n lands in word n/2, low half for even n and high half for odd n.
    assign load_idx_s   = {2'b00, n_r[3:1]};
    assign out_idx_s    = {2'b00, k_r[3:1]};
    assign load_word_s  = n_r[0] ? {idata, 16'h0000} : {16'h0000, idata};
    assign round_last_s = (rcnt_r == rcnt_last_s);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; init restarts IV generation from any state.
    always_comb begin
        state_next_s = state_r;
        if (init) begin
            state_next_s = ST_IVGEN;
        end else begin
            case (state_r)
                ST_IVGEN: begin
                    if (round_last_s) state_next_s = ST_READY;
                    else              state_next_s = ST_IVGEN;
                end
                ST_READY: begin
                    if (take_load_s && (n_r == 4'd15)) state_next_s = ST_ROUND;
                    else if (start_final_s)             state_next_s = ST_FINAL;
                    else                                state_next_s = ST_READY;
                end
                ST_ROUND: begin
                    if (round_last_s) state_next_s = ST_READY;
                    else              state_next_s = ST_ROUND;
                end
                ST_FINAL: begin
                    if (round_last_s) state_next_s = ST_OUTPUT;
                    else              state_next_s = ST_FINAL;
                end
                ST_OUTPUT: begin
                    if (deliver_s && (k_r == 4'd15)) state_next_s = ST_DONE;
                    else                             state_next_s = ST_OUTPUT;
                end
                ST_IDLE:  state_next_s = ST_IDLE;
                ST_DONE:  state_next_s = ST_DONE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // Per-state control decode: round enable/limit and accepted requests.
    // In READY a load takes precedence over a simultaneous fetch.
    always_comb begin
        round_en_s    = 1'b0;
        rcnt_last_s   = 8'd0;
        take_load_s   = 1'b0;
        start_final_s = 1'b0;
        deliver_s     = 1'b0;
        case (state_r)
            ST_IVGEN: begin
                round_en_s  = 1'b1;
                rcnt_last_s = RCNT_INIT_LAST;
            end
            ST_ROUND: begin
                round_en_s  = 1'b1;
                rcnt_last_s = RCNT_BLOCK_LAST;
            end
            ST_FINAL: begin
                round_en_s  = 1'b1;
                rcnt_last_s = RCNT_FINAL_LAST;
            end
            ST_READY: begin
                if (load) begin
                    take_load_s = 1'b1;
                end else if (fetch && (n_r == 4'd0)) begin
                    start_final_s = 1'b1;
                end else begin
                    take_load_s   = 1'b0;
                    start_final_s = 1'b0;
                end
            end
            ST_OUTPUT: begin
                deliver_s = fetch;
            end
            default: begin
                round_en_s = 1'b0;
            end
        endcase
    end

    // Hash state, word counter and round counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= '0;
            n_r    <= 4'd0;
            rcnt_r <= 8'd0;
        end else if (init) begin
            x_r    <= iv_state();
            n_r    <= 4'd0;
            rcnt_r <= 8'd0;
        end else if (round_en_s) begin
            x_r    <= x_round_s;
            rcnt_r <= round_last_s ? 8'd0 : (rcnt_r + 8'd1);
        end else if (take_load_s) begin
            x_r[load_idx_s] <= x_r[load_idx_s] ^ load_word_s;
            n_r             <= n_r + 4'd1;
        end else if (start_final_s) begin
            x_r[5'd31] <= x_r[5'd31] ^ 32'd1;
        end else begin
            x_r <= x_r;
        end
    end

    // Handshake outputs: ack pulse per accepted/delivered word, odata held.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack   <= 1'b0;
            odata <= 16'h0000;
            k_r   <= 4'd0;
        end else if (init) begin
            ack   <= 1'b0;
            k_r   <= 4'd0;
        end else begin
            ack <= take_load_s | deliver_s;
            if (deliver_s) begin
                odata <= k_r[0] ? x_r[out_idx_s][31:16] : x_r[out_idx_s][15:0];
                k_r   <= k_r + 4'd1;
            end else begin
                odata <= odata;
            end
        end
    end

`ifdef CUBEHASH_ERR_EN
    logic err_set_s;
    logic err_r;

    // Requests the core must drop in its current state.
    always_comb begin
        err_set_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE:    err_set_s = load | fetch;
            ST_READY:            err_set_s = ~load & fetch & (n_r != 4'd0);
            ST_FINAL, ST_OUTPUT: err_set_s = load;
            default:             err_set_s = 1'b0;
        endcase
    end

    // Sticky error flag, cleared by reset or init.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (init) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`endif

endmodule

// File: tb/tb_cubehash_top.sv
// Scoreboard bench for cubehash_top. The driver predicts, from the timing
// rules, the edge on which each word is accepted or delivered and pushes that
// expectation; a negedge monitor matches every ack against the queue. Digest
// words come from a byte-level CubeHash16/32-256 model kept in the bench.
module tb_cubehash_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic        load;
    logic        fetch;
    logic [15:0] idata;
    logic        ack;
    logic [15:0] odata;
`ifdef CUBEHASH_ERR_EN
    logic        err;
`endif

    cubehash_top dut (
        .clk   (clk),
        .rst   (rst),
        .init  (init),
        .load  (load),
        .fetch (fetch),
        .idata (idata),
        .ack   (ack),
        .odata (odata)
`ifdef CUBEHASH_ERR_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        bit          has_data;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  msg_q[$];
    logic [31:0] mx[32];
    logic [15:0] dg[16];
    int          edge_cnt = 0;
    int          checks   = 0;
    int          passes   = 0;
    bit          mon_en   = 1'b0;
    int          ready_edge;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Each swap step is expressed as a permutation of indices.
    function automatic void mdl_round();
        logic [31:0] t[32];
        for (int i = 16; i < 32; i++) mx[i] = mx[i] + mx[i - 16];
        for (int i = 0; i < 16; i++)  mx[i] = rotl(mx[i], 7);
        t = mx;
        for (int i = 0; i < 16; i++)  mx[i] = t[i ^ 8];
        for (int i = 0; i < 16; i++)  mx[i] = mx[i] ^ mx[i + 16];
        t = mx;
        for (int i = 16; i < 32; i++) mx[i] = t[i ^ 2];
        for (int i = 16; i < 32; i++) mx[i] = mx[i] + mx[i - 16];
        for (int i = 0; i < 16; i++)  mx[i] = rotl(mx[i], 11);
        t = mx;
        for (int i = 0; i < 16; i++)  mx[i] = t[i ^ 4];
        for (int i = 0; i < 16; i++)  mx[i] = mx[i] ^ mx[i + 16];
        t = mx;
        for (int i = 16; i < 32; i++) mx[i] = t[i ^ 1];
    endfunction

    function automatic void mdl_init();
        for (int i = 0; i < 32; i++) mx[i] = 32'd0;
        mx[0] = 32'd32;   // h/8
        mx[1] = 32'd32;   // b
        mx[2] = 32'd16;   // r
        for (int r = 0; r < 160; r++) mdl_round();
    endfunction

    // Little-endian byte absorption of one 32-byte block.
    function automatic void mdl_block(input int base);
        for (int j = 0; j < 32; j++)
            mx[j / 4] = mx[j / 4] ^ ({24'd0, msg_q[base + j]} << (8 * (j % 4)));
        for (int r = 0; r < 16; r++) mdl_round();
    endfunction

    function automatic void mdl_final();
        logic [7:0] lo, hi;
        mx[31] = mx[31] ^ 32'd1;
        for (int r = 0; r < 160; r++) mdl_round();
        for (int k = 0; k < 16; k++) begin
            lo    = 8'(mx[(2 * k) / 4]     >> (8 * ((2 * k) % 4)));
            hi    = 8'(mx[(2 * k + 1) / 4] >> (8 * ((2 * k + 1) % 4)));
            dg[k] = {hi, lo};
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic wait_edge(input int e);
        while (edge_cnt < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full hash of a random message of len bytes; delivers stop_k digest words.
    task automatic hash_flow(input int len, input bit fetch_held, input int stop_k);
        int nblk;
        int e;
        int e0;
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
        msg_q.push_back(8'h80);
        while ((msg_q.size() % 32) != 0) msg_q.push_back(8'h00);
        nblk = msg_q.size() / 32;

        load  = 1'b0;
        fetch = fetch_held;
        init  = 1'b1;
        @(posedge clk);
        #1;
        init       = 1'b0;
        ready_edge = edge_cnt + 161;
        mdl_init();
`ifdef CUBEHASH_ERR_EN
        check16("err_cleared_by_init", {15'd0, err}, 16'd0);
`endif
        for (int b = 0; b < nblk; b++) begin
            for (int n = 0; n < 16; n++) begin
                load  = 1'b1;
                idata = {msg_q[32 * b + 2 * n + 1], msg_q[32 * b + 2 * n]};
                e     = (ready_edge > edge_cnt + 1) ? ready_edge : edge_cnt + 1;
                exp_q.push_back('{e, 1'b0, 16'h0000});
                wait_edge(e);
                ready_edge = (n == 15) ? e + 17 : e + 1;
            end
            mdl_block(32 * b);
        end
        load  = 1'b0;
        fetch = 1'b1;
        e0    = (ready_edge > edge_cnt + 1) ? ready_edge : edge_cnt + 1;
        mdl_final();
        for (int k = 0; k < stop_k; k++) exp_q.push_back('{e0 + 161 + k, 1'b1, dg[k]});
        wait_edge(e0 + 160 + stop_k);
    endtask

    // Extra fetches in DONE must not ack; odata keeps the last digest word.
    task automatic after_done();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
`ifdef CUBEHASH_ERR_EN
        check16("err_fetch_in_done", {15'd0, err}, 16'd1);
`endif
        check16("odata_held", odata, dg[15]);
        fetch = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if ((exp_q.size() > 0) && (exp_q[0].edge_no == edge_cnt)) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (ack !== 1'b1)
                    $display("FAIL ack_missing: edge %0d ack=%b, expected 1", edge_cnt, ack);
                else if (mon_e.has_data && (odata !== mon_e.data))
                    $display("FAIL digest_word: edge %0d odata=%h, expected %h", edge_cnt, odata, mon_e.data);
                else
                    passes++;
            end else if (ack !== 1'b0) begin
                checks++;
                $display("FAIL ack_unexpected: edge %0d ack=%b, expected 0", edge_cnt, ack);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: edge %0d reached, expected finish earlier", edge_cnt);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        init  = 1'b0;
        load  = 1'b0;
        fetch = 1'b0;
        idata = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        check16("reset_ack", {15'd0, ack}, 16'd0);
        check16("reset_odata", odata, 16'h0000);

        // Requests in IDLE are dropped.
        load  = 1'b1;
        fetch = 1'b1;
        idata = 16'h1234;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check16("idle_odata", odata, 16'h0000);
`ifdef CUBEHASH_ERR_EN
        check16("err_idle_request", {15'd0, err}, 16'd1);
`endif
        load  = 1'b0;
        fetch = 1'b0;

        // Empty message, fetch raised after the block, then held throughout.
        hash_flow(0, 1'b0, 16);
        after_done();
        hash_flow(0, 1'b1, 16);
        after_done();

        // Random multi-block messages.
        for (int t = 0; t < 3; t++) begin
            hash_flow($urandom_range(1, 100), 1'($urandom_range(0, 1)), 16);
            after_done();
        end

        // Init while outputting word 5, then a complete fresh hash.
        hash_flow($urandom_range(0, 40), 1'b1, 5);
        hash_flow($urandom_range(0, 40), 1'b0, 16);
        after_done();

        // Reset in the middle of IV generation.
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check16("midop_reset_ack", {15'd0, ack}, 16'd0);
        check16("midop_reset_odata", odata, 16'h0000);
        load = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        hash_flow(33, 1'b0, 16);
        after_done();

        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check16("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cubehash_top.md
# cubehash_top

Iterative CubeHash16/32-256 hash core with a 16-bit load/fetch handshake. The core holds the 1024-bit state as 32 32-bit words, computes one full round per clock, and absorbs pre-padded 32-byte message blocks. It produces the 256-bit digest as 16 16-bit words. It sits behind a host or bus adapter that drives the init/load/fetch strobes.

## Interface
- Parameters: none. r=16, b=32 bytes, h=256 bits, init rounds 160 and final rounds 160 are fixed constants.
- Reset is synchronous and active-high. The block has a single clock.
- clk  in  1  Rising-edge clock.
- rst  in  1  Synchronous active-high reset.
- init  in  1  Single-cycle pulse that starts IV generation.
- load  in  1  Level request to absorb idata.
- fetch  in  1  Level request for the next digest word.
- idata  in  16  Message halfword. idata[7:0] is the earlier byte.
- ack  out  1  Registered pulse: a word was accepted or delivered.
- odata  out  16  Digest halfword. Valid while ack=1 and held until the next delivery.

## Operation
- States: IDLE, IVGEN, READY, ROUND, FINAL, OUTPUT, DONE.
- init is honoured in any state, including mid-block or mid-output.
  - It sets x0=32, x1=32, x2=16 and x3..x31=0.
  - It clears the word counter and output index, then enters IVGEN.
- IVGEN runs 160 rounds, then goes to READY.
- READY, on an edge with load=1:
  - The halfword n (0..15) is stored into x[n/2]. It is XORed into bits [15:0] if n is even and [31:16] if n is odd.
  - ack is set, n is incremented.
  - After n=15 the core enters ROUND for 16 rounds, then returns to READY with n=0.
- The host performs padding: append byte 0x80, then zero-fill to a multiple of 32 bytes.
- READY with n=0, on an edge with fetch=1: set x31 ^= 1 and enter FINAL for 160 rounds, then OUTPUT.
- OUTPUT, on an edge with fetch=1:
  - odata is set to halfword k of x0..x7, in the same mapping as load.
  - ack is set and k is incremented.
  - After k=15 the core enters DONE.
- Ignored requests, with ack staying 0:
  - load or fetch while busy (IVGEN/ROUND/FINAL); the host keeps the request high until ack.
  - load in FINAL, OUTPUT or DONE.
  - fetch in READY when n≠0.
  - any request in IDLE or DONE.
- Round (i = 5-bit index; "add" is mod 2^32):
  1. x[1jklm] += x[0jklm]
  2. x[0jklm] rotl 7
  3. swap x[00klm] with x[01klm]
  4. x[0jklm] ^= x[1jklm]
  5. swap x[1jk0m] with x[1jk1m]
  6. x[1jklm] += x[0jklm]
  7. x[0jklm] rotl 11
  8. swap x[0j0lm] with x[0j1lm]
  9. x[0jklm] ^= x[1jklm]
  10. swap x[1jkl0] with x[1jkl1]

## Timing
- Reset values: ack=0, odata=0, state=IDLE, all x=0, n=k=0.
- Reset takes priority over init. Reset mid-operation returns the core to IDLE.
- ack is a one-cycle pulse, high during the cycle after each capturing edge.
  - With load or fetch held high, the core accepts or delivers one word per clock.
- The init pulse edge is followed by 160 cycles of busy, then READY.
- The edge capturing the 16th halfword is followed by 16 cycles of busy, then READY.
  - A load held high is accepted on the first READY edge.
- The fetch edge in READY is followed by 160 cycles of FINAL.
  - On the next edge with fetch=1, word 0 is delivered.

## Configuration
- CUBEHASH_ERR_EN defined: add output err (1 bit, reset 0, sticky).
  - err is set by any ignored request in IDLE, DONE, or READY with n≠0.
  - err is set by load in FINAL or OUTPUT.
  - err is cleared by rst or init.
- CUBEHASH_ERR_EN undefined: no err port, and ignored requests are silently dropped.

## Structure
- Package cubehash_pkg holds:
  - constants ROUNDS_BLOCK=16, ROUNDS_INIT=160, ROUNDS_FINAL=160, IV_X0=32, IV_X1=32, IV_X2=16;
  - the state enum;
  - the typedef state_words_t (32×32 bits).
- Sub-module cubehash_round is purely combinational and maps 1024-bit state in to 1024-bit state out. It is instantiated once.

## Test plan
- Reset: assert rst for 3 cycles, then drive load=1 and fetch=1 → ack=0, odata=0000, and no state change (err=1 if enabled).
- Init latency: pulse init, then hold load=1 with idata=0x0080 → the first ack comes exactly 161 edges after the init edge.
- Block stream: load held for 16 words → 16 consecutive ack pulses, then ack=0 for 16 cycles. The next held word is acked on the 17th edge.
- Empty message: init, then one block (first word 0x0080, then 15 words 0x0000), then fetch held → 16 ack pulses. The odata sequence must equal the CubeHash16/32-256 golden-model digest of "".
- Same flow with fetch held throughout: ack only from word 0, and 16 deliveries in 16 cycles. A 17th fetch gives no ack (err=1 if enabled).
- Init during OUTPUT at k=5 → ack=0 for 160 cycles, then a full fresh hash matches the golden model.
